// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter that drives the one-hot enables of several tristate drivers sharing one bus net.
// It enforces dead turnaround cycles between owners and a hold limit so that no requester starves.
module tri_bus_arbiter #(
  parameter int N_REQ      = 2,
  parameter int MAX_HOLD   = 4,
  parameter int TURNAROUND = 1,
  localparam int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  owner_id,
  output logic             bus_busy,
  output logic             turn
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TURN_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_TURN  = 2'd2;

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_MAX = TURN_W'(TURNAROUND - 1);

  logic [1:0]        state_r;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [TURN_W-1:0] turn_cnt_r;

  logic              arb_hit_s;
  logic [ID_W-1:0]   arb_idx_s;
  logic [N_REQ-1:0]  arb_grant_s;
  int                best_dist_s;
  logic              owner_req_s;
  logic              others_s;
  logic              release_s;

  // Distance of requester idx from the slot just after ptr in round-robin order.
  function automatic int rr_dist(input int idx, input logic [ID_W-1:0] ptr);
    return (idx + 2 * N_REQ - int'(ptr) - 1) % N_REQ;
  endfunction

  // Round-robin search: closest pending requester after the last owner wins.
  always_comb begin
    arb_hit_s   = 1'b0;
    arb_idx_s   = '0;
    best_dist_s = N_REQ;
    for (int j = 0; j < N_REQ; j++) begin
      if (req[j] && (rr_dist(j, rr_ptr_r) < best_dist_s)) begin
        arb_hit_s   = 1'b1;
        arb_idx_s   = ID_W'(j);
        best_dist_s = rr_dist(j, rr_ptr_r);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    if (arb_hit_s) begin
      arb_grant_s = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx_s;
    end else begin
      arb_grant_s = '0;
    end
  end

  // Release decision for the current owner; grant is one-hot in GRANT so it masks the owner.
  always_comb begin
    owner_req_s = |(req & grant);
    others_s    = |(req & ~grant);
    release_s   = (!owner_req_s) || (others_s && (hold_cnt_r == HOLD_MAX));
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      grant      <= '0;
      owner_id   <= '0;
      bus_busy   <= 1'b0;
      turn       <= 1'b0;
      rr_ptr_r   <= ID_W'(N_REQ - 1);
      hold_cnt_r <= '0;
      turn_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_GRANT: begin
          if (release_s) begin
            grant      <= '0;
            bus_busy   <= 1'b0;
            turn       <= 1'b1;
            turn_cnt_r <= TURN_MAX;
            state_r    <= ST_TURN;
          end else if (hold_cnt_r != HOLD_MAX) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        ST_IDLE, ST_TURN: begin
          if ((state_r == ST_TURN) && (turn_cnt_r != '0)) begin
            turn_cnt_r <= turn_cnt_r - TURN_W'(1);
          end else begin
            turn       <= 1'b0;
            grant      <= arb_grant_s;
            bus_busy   <= arb_hit_s;
            hold_cnt_r <= '0;
            if (arb_hit_s) begin
              owner_id <= arb_idx_s;
              rr_ptr_r <= arb_idx_s;
              state_r  <= ST_GRANT;
            end else begin
              state_r  <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          grant    <= '0;
          bus_busy <= 1'b0;
          turn     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench: two tristate drivers (8'd2, 8'd3) share one bus, and their enables come from the arbiter.
// The DUT is compared against an ownership/dead-time model in directed and random phases.
module tb_tri_bus_arbiter;

  localparam int N          = 2;
  localparam int MAX_HOLD   = 4;
  localparam int TURNAROUND = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic [0:0] owner_id;
  logic       bus_busy;
  logic       turn;
  wire  [7:0] bus;

  int compared = 0;
  int mismatched = 0;

  // Reference model: current owner (-1 = none), cycles owned, dead cycles left, and last owner.
  int m_owner = -1;
  int m_held  = 0;
  int m_dead  = 0;
  int m_last  = N - 1;
  logic [1:0] seq2 [11];

  tri_bus_arbiter #(.N_REQ(N), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .owner_id(owner_id), .bus_busy(bus_busy), .turn(turn)
  );

  assign bus = grant[0] ? 8'd2 : 8'hzz;
  assign bus = grant[1] ? 8'd3 : 8'hzz;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_pick(input logic [1:0] r);
    m_owner = -1;
    for (int i = 1; i <= N; i++) begin
      if (m_owner < 0 && r[(m_last + i) % N]) m_owner = (m_last + i) % N;
    end
    if (m_owner >= 0) begin
      m_last = m_owner;
      m_held = 1;
    end
  endtask

  task automatic step(input logic [1:0] r, input logic rs, input string tag);
    logic [1:0] eg;
    req = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_owner = -1; m_held = 0; m_dead = 0; m_last = N - 1;
    end else if (m_owner >= 0) begin
      if (!r[m_owner] || (m_held >= MAX_HOLD && (r & ~(2'b01 << m_owner)) != 2'b00)) begin
        m_owner = -1;
        m_dead  = TURNAROUND;
      end else begin
        m_held++;
      end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) model_pick(r);
    end else begin
      model_pick(r);
    end
    #1;
    eg = (m_owner >= 0) ? (2'b01 << m_owner) : 2'b00;
    chk({tag, ".grant"}, {6'd0, grant}, {6'd0, eg});
    chk({tag, ".busy"}, {7'd0, bus_busy}, {7'd0, m_owner >= 0});
    chk({tag, ".turn"}, {7'd0, turn}, {7'd0, m_dead > 0});
    chk({tag, ".not11"}, {7'd0, grant == 2'b11}, 8'd0);
    if (m_owner >= 0) begin
      chk({tag, ".owner"}, {7'd0, owner_id}, 8'(m_owner));
      chk({tag, ".bus"}, bus, (m_owner == 0) ? 8'd2 : 8'd3);
      chk({tag, ".busx"}, {7'd0, $isunknown(bus)}, 8'd0);
    end else if (rs) begin
      chk({tag, ".rst_owner"}, {7'd0, owner_id}, 8'd0);
    end
  endtask

  initial begin
    logic [1:0] r;
    logic [1:0] seq2_exp [11];
    seq2_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    // 1: single request, then release with one turnaround cycle
    step(2'b00, 1'b1, "t1_rst");
    step(2'b01, 1'b0, "t1_req");
    step(2'b00, 1'b0, "t1_rel");
    step(2'b00, 1'b0, "t1_idle");
    step(2'b00, 1'b0, "t1_idle2");

    // 2: both requesting, hold limit forces rotation
    step(2'b00, 1'b1, "t2_rst");
    for (int i = 0; i < 11; i++) begin
      step(2'b11, 1'b0, "t2");
      seq2[i] = grant;
    end
    for (int i = 0; i < 11; i++) chk($sformatf("t2_seq%0d", i), {6'd0, seq2[i]}, {6'd0, seq2_exp[i]});

    // 3: sole requester keeps the bus with no turnaround
    step(2'b00, 1'b1, "t3_rst");
    for (int i = 0; i < 10; i++) step(2'b01, 1'b0, "t3");

    // 4: owner 0 drops while 1 waits; 0 re-raised during TURN still loses
    step(2'b10, 1'b0, "t4_rel");
    step(2'b11, 1'b0, "t4_turn");
    step(2'b11, 1'b0, "t4_g1");

    // 5: reset while grant=10, then req=11 goes to 0
    step(2'b00, 1'b1, "t5_rst");
    step(2'b10, 1'b0, "t5_g1");
    step(2'b10, 1'b0, "t5_hold");
    step(2'b10, 1'b1, "t5_midrst");
    step(2'b11, 1'b0, "t5_g0");

    // 6: owner drops and re-raises in TURN with no competitor
    step(2'b00, 1'b1, "t6_rst");
    step(2'b01, 1'b0, "t6_g0");
    step(2'b00, 1'b0, "t6_rel");
    step(2'b01, 1'b0, "t6_regrant");
    step(2'b01, 1'b0, "t6_hold");

    // Random phase: requests mostly held, occasional reset
    r = 2'b00;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 2'($urandom_range(0, 3));
      step(r, $urandom_range(0, 59) == 0, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
